// File: rtl/stall_sink_pkg.sv
// stall_sink_pkg: shared widths and default sizing for the stall sink
package stall_sink_pkg;
  localparam int DATA_W = 32;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_SKID = 2;
  localparam int DEF_DRAIN_PERIOD = 4;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/stall_sink_lane.sv
// stall_sink_lane: one lane FIFO with rate-limited drain, stall and overflow; STALL_SINK_CHECKSUM_EN adds a popped-word sum
module stall_sink_lane
  import stall_sink_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SKID = DEF_SKID,
  parameter int DRAIN_PERIOD = DEF_DRAIN_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              stall,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef STALL_SINK_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              overflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int DW = cnt_w(DRAIN_PERIOD);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] THR = CW'(DEPTH - SKID);
  localparam logic [DW-1:0] LAST = DW'(DRAIN_PERIOD - 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] drain_cnt;
  logic pop, push;
  // a pop frees the slot this cycle, so a full FIFO still takes a push on the drain slot
  always_comb begin
    pop = (drain_cnt == LAST) && (count != '0);
    push = valid && ((count != FULL) || pop);
  end
  assign stall = count >= THR;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      drain_cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      drain_cnt <= (drain_cnt == LAST) ? '0 : drain_cnt + 1'b1;
      out_valid <= pop;
      if (pop) out_data <= mem[rd_ptr];
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (valid && !push) overflow <= 1'b1;
    end
  end
`ifdef STALL_SINK_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) checksum <= '0;
    else if (pop) checksum <= checksum + mem[rd_ptr];
  end
`endif
endmodule

// File: rtl/stall_sink_fsm.sv
// stall_sink_fsm: dual-lane stall-protocol receiver; STALL_SINK_CHECKSUM_EN adds checksum_1/checksum_2
module stall_sink_fsm
  import stall_sink_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SKID = DEF_SKID,
  parameter int DRAIN_PERIOD = DEF_DRAIN_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pipeline1_outputs,
  input  logic [DATA_W-1:0] pipeline2_outputs,
  input  logic              valid_1,
  input  logic              valid_2,
  output logic              out_stall_1,
  output logic              out_stall_2,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic              out_valid_1,
  output logic              out_valid_2,
`ifdef STALL_SINK_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum_1,
  output logic [DATA_W-1:0] checksum_2,
`endif
  output logic              overflow_1,
  output logic              overflow_2
);
  stall_sink_lane #(.DEPTH(DEPTH), .SKID(SKID), .DRAIN_PERIOD(DRAIN_PERIOD)) u_lane1 (
    .clk(clk), .reset(reset), .valid(valid_1), .data(pipeline1_outputs),
    .stall(out_stall_1), .out_data(out_data_1), .out_valid(out_valid_1),
`ifdef STALL_SINK_CHECKSUM_EN
    .checksum(checksum_1),
`endif
    .overflow(overflow_1)
  );
  stall_sink_lane #(.DEPTH(DEPTH), .SKID(SKID), .DRAIN_PERIOD(DRAIN_PERIOD)) u_lane2 (
    .clk(clk), .reset(reset), .valid(valid_2), .data(pipeline2_outputs),
    .stall(out_stall_2), .out_data(out_data_2), .out_valid(out_valid_2),
`ifdef STALL_SINK_CHECKSUM_EN
    .checksum(checksum_2),
`endif
    .overflow(overflow_2)
  );
endmodule

// File: tb/tb_stall_sink_fsm.sv
// tb_stall_sink_fsm: table vectors on a DRAIN_PERIOD=1 instance, queue-model checks on a default instance
module tb_stall_sink_fsm;
  localparam int P = 4;
  localparam int D = 8;
  localparam int S = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, v1, v2;
  logic [31:0] d1, d2;
  logic st1, st2, ov1, ov2, ova1, ova2;
  logic [31:0] od1, od2;
`ifdef STALL_SINK_CHECKSUM_EN
  logic [31:0] cs1, cs2;
`endif

  logic br, bv1, bv2;
  logic [31:0] bd1, bd2;
  logic bst1, bst2, bov1, bov2, bova1, bova2;
  logic [31:0] bod1, bod2;
`ifdef STALL_SINK_CHECKSUM_EN
  logic [31:0] bcs1, bcs2;
`endif

  stall_sink_fsm dut (
    .clk(clk), .reset(reset), .pipeline1_outputs(d1), .pipeline2_outputs(d2),
    .valid_1(v1), .valid_2(v2), .out_stall_1(st1), .out_stall_2(st2),
    .out_data_1(od1), .out_data_2(od2), .out_valid_1(ov1), .out_valid_2(ov2),
`ifdef STALL_SINK_CHECKSUM_EN
    .checksum_1(cs1), .checksum_2(cs2),
`endif
    .overflow_1(ova1), .overflow_2(ova2)
  );

  stall_sink_fsm #(.DRAIN_PERIOD(1)) dut_fast (
    .clk(clk), .reset(br), .pipeline1_outputs(bd1), .pipeline2_outputs(bd2),
    .valid_1(bv1), .valid_2(bv2), .out_stall_1(bst1), .out_stall_2(bst2),
    .out_data_1(bod1), .out_data_2(bod2), .out_valid_1(bov1), .out_valid_2(bov2),
`ifdef STALL_SINK_CHECKSUM_EN
    .checksum_1(bcs1), .checksum_2(bcs2),
`endif
    .overflow_1(bova1), .overflow_2(bova2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // reference model: per-lane queue, pop on every P-th edge after reset
  logic [31:0] mq [2][$];
  logic [31:0] md [2];
  logic [31:0] msum [2];
  logic mv [2];
  logic mov [2];
  int n;
  logic [31:0] got1 [$];
  logic [31:0] got2 [$];

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      mq[l].delete();
      md[l] = 0; msum[l] = 0; mv[l] = 0; mov[l] = 0;
    end
    n = 0;
  endtask

  task automatic lane_step(input int l, input bit slot, input logic v, input logic [31:0] d);
    bit full, pop;
    full = mq[l].size() == D;
    pop = slot && mq[l].size() > 0;
    mv[l] = pop;
    if (pop) begin
      md[l] = mq[l].pop_front();
      msum[l] = msum[l] + md[l];
    end
    if (v) begin
      if (!full || pop) mq[l].push_back(d);
      else mov[l] = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic a1, input logic [31:0] x1,
                      input logic a2, input logic [31:0] x2);
    bit slot;
    reset = r; v1 = a1; d1 = x1; v2 = a2; d2 = x2;
    @(posedge clk);
    if (r) model_reset();
    else begin
      slot = (n % P) == P - 1;
      n++;
      lane_step(0, slot, a1, x1);
      lane_step(1, slot, a2, x2);
    end
    #1;
    check("valid_1", 32'(ov1), 32'(mv[0]));
    check("valid_2", 32'(ov2), 32'(mv[1]));
    check("data_1", od1, md[0]);
    check("data_2", od2, md[1]);
    check("stall_1", 32'(st1), 32'(mq[0].size() >= D - S));
    check("stall_2", 32'(st2), 32'(mq[1].size() >= D - S));
    check("overflow_1", 32'(ova1), 32'(mov[0]));
    check("overflow_2", 32'(ova2), 32'(mov[1]));
`ifdef STALL_SINK_CHECKSUM_EN
    check("checksum_1", cs1, msum[0]);
    check("checksum_2", cs2, msum[1]);
`endif
    if (ov1) got1.push_back(od1);
    if (ov2) got2.push_back(od2);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic r, v1; logic [31:0] d1; logic v2; logic [31:0] d2;
    logic ev1; logic [31:0] ed1; logic ev2; logic [31:0] ed2;
  } tv_t;
  tv_t tv [8];

  initial begin
    tv[0] = '{1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0};
    tv[1] = '{0, 1, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0, 0, 32'h0};
    tv[2] = '{0, 0, 32'h0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0};
    tv[3] = '{0, 0, 32'h0, 0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0};
    tv[4] = '{0, 1, 32'h1, 1, 32'h2, 0, 32'hDEADBEEF, 0, 32'h0};
    tv[5] = '{0, 1, 32'h3, 0, 32'h0, 1, 32'h1, 1, 32'h2};
    tv[6] = '{0, 0, 32'h0, 0, 32'h0, 1, 32'h3, 0, 32'h2};
    tv[7] = '{0, 0, 32'h0, 0, 32'h0, 0, 32'h3, 0, 32'h2};
    reset = 1; v1 = 0; v2 = 0; d1 = 0; d2 = 0;
    br = 1; bv1 = 0; bv2 = 0; bd1 = 0; bd2 = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      br = tv[i].r; bv1 = tv[i].v1; bd1 = tv[i].d1; bv2 = tv[i].v2; bd2 = tv[i].d2;
      @(posedge clk); #1;
      check($sformatf("fast_valid_1[%0d]", i), 32'(bov1), 32'(tv[i].ev1));
      check($sformatf("fast_data_1[%0d]", i), bod1, tv[i].ed1);
      check($sformatf("fast_valid_2[%0d]", i), 32'(bov2), 32'(tv[i].ev2));
      check($sformatf("fast_data_2[%0d]", i), bod2, tv[i].ed2);
      check($sformatf("fast_stall_1[%0d]", i), 32'(bst1), 32'h0);
    end
    br = 1;

    // continuous lane-1 words until stall, then two more in flight
    step(1, 0, 0, 0, 0);
    got1.delete();
    begin
      logic [31:0] w;
      bit seen;
      w = 1; seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
        step(0, 1, w, 0, 0);
        w++;
        seen = st1;
      end
      if (!seen) check("t3_stall_seen", 32'h0, 32'h1);
      step(0, 1, w, 0, 0); w++;
      step(0, 1, w, 0, 0); w++;
      idle(50);
      check("t3_overflow", 32'(ova1), 32'h0);
      check("t3_count", got1.size(), w - 1);
      foreach (got1[i]) check("t3_order", got1[i], i + 1);
    end

    // 12 back-to-back lane-2 words ignoring stall
    step(1, 0, 0, 0, 0);
    got2.delete();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 32'd100 + i);
    check("t4_overflow", 32'(ova2), 32'h1);
    idle(50);
    check("t4_overflow_sticky", 32'(ova2), 32'h1);
    for (int i = 1; i < got2.size(); i++) check("t4_ascending", 32'(got2[i] > got2[i-1]), 32'h1);

    // full FIFO, push on the drain slot
    step(1, 0, 0, 0, 0);
    got1.delete();
    for (int i = 0; i < 30 && mq[0].size() < D; i++) step(0, 1, 32'h50 + i, 0, 0);
    while ((n % P) != P - 1) step(0, 0, 0, 0, 0);
    step(0, 1, 32'hA5A5A5A5, 0, 0);
    check("t5_stall", 32'(st1), 32'h1);
    check("t5_overflow", 32'(ova1), 32'h0);
    idle(50);
    check("t5_last", got1[$], 32'hA5A5A5A5);

    // reset mid-burst, then a fresh word emerges first
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h700 + i, 1, 32'h800 + i);
    for (int i = 0; i < 3; i++) step(1, 1, 32'hBAD0 + i, 1, 32'hBAD0 + i);
    check("t1_rst_data", od1, 32'h0);
    check("t1_rst_valid", 32'(ov1), 32'h0);
    got1.delete();
    step(0, 1, 32'h1234, 0, 0);
    idle(8);
    check("t1_first", got1.size() > 0 ? got1[0] : 32'hFFFF_FFFF, 32'h1234);

`ifdef STALL_SINK_CHECKSUM_EN
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'hFFFFFFFF, 0, 0);
    step(0, 1, 32'h00000002, 0, 0);
    idle(10);
    check("t6_checksum", cs1, 32'h00000001);
`endif

    // randomized traffic with occasional reset
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 1) != 0, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
